regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with a write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-cycle CPU's two-read register file in the pipelined core and sits between decode, which reads operands and issues destinations, and writeback, which commits results. Decode uses the scoreboard outputs to stall on RAW hazards, and the flush input discards in-flight destinations after a branch mispredict.

## Interface
- DATA_WIDTH, 32: register width in bits
- NUM_REGS, 32: number of architectural registers, power of two, ≥ 4; AW = $clog2(NUM_REGS)
- NUM_READ, 2: number of read ports, 1..4
- RA_INDEX, NUM_REGS-1: destination forced by write_ra (link register)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  NUM_READ×AW  read addresses, packed, port 0 in LSBs
- rd_data  out  NUM_READ×DATA_WIDTH  read data per port
- rd_pending  out  NUM_READ  addressed register has an outstanding write
- wr_en  in  1  commit write_data this cycle
- wr_ra  in  1  with wr_en, write to RA_INDEX regardless of wr_addr
- wr_addr  in  AW  write destination
- wr_data  in  DATA_WIDTH  write data
- iss_en  in  1  mark iss_addr pending (instruction issued)
- iss_addr  in  AW  destination being issued
- flush  in  1  synchronous clear of all pending bits
- pend_count  out  AW+1  number of registers currently pending

## Operation
- Register 0 reads 0 and is never written or marked pending. Writes and issues to index 0 are ignored.
- Effective write address: wr_ra ? RA_INDEX : wr_addr.
- Reads are combinational per port and independent. Any number of ports may alias the same address.
- Scoreboard holds one pending bit per register, 1..NUM_REGS-1:
  - set by iss_en on iss_addr;
  - cleared by wr_en on the effective write address;
  - when set and clear hit the same register in one cycle, set wins (a newer writer exists);
  - flush clears every bit and has priority over set and clear in the same cycle. Register contents are unaffected by flush, and a write in that cycle still commits.
- pend_count is registered and equals the population count of the pending bits after each edge. It is maintained incrementally (+1 on set of a clear bit, −1 on clear of a set bit, net 0 on simultaneous set/clear), reset to 0 by flush, and never wraps; its range is 0..NUM_REGS-1.
- Reset values: every register is 0, every pending bit is 0, pend_count is 0, and hence rd_data and rd_pending are all 0.
- Reset asserted mid-operation clears state immediately. Pending writes are discarded, not committed.

## Timing
- Write latency is 1: data written at edge N is visible on rd_data from edge N onward.
- Issue latency is 1: rd_pending rises the cycle after iss_en.
- Bypass (when compiled in): a read whose address equals an active effective write address in the same cycle returns wr_data, and its rd_pending is 0 unless iss_en targets that address in an earlier-committed cycle.
- Without bypass, a same-cycle read returns the old value, and rd_pending stays 1 until the edge.
- No handshake; all inputs are sampled every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding on data and pending, as above.
- REGFILE_BYPASS_EN undefined: reads reflect only the registered state. This is a shorter combinational path, and decode must then stall one extra cycle after writeback.

## Structure
- Package regfile_pkg holds:
  - default DATA_WIDTH and NUM_REGS;
  - typedef reg_addr_t (AW bits);
  - named index constants REG_ZERO, REG_SP, REG_FP, REG_RA.
- Sub-module regfile_scoreboard contains the pending bits, the priority logic and pend_count. The top level holds the storage array, the read muxes and the bypass.

## Test plan
- Reset, then read all indices on all ports: rd_data = 0, rd_pending = 0, pend_count = 0.
- Write 0xDEADBEEF to r5; next cycle ports 0 and 1 both read r5: both return 0xDEADBEEF. Write to r0, then read r0: returns 0.
- wr_en=1, wr_ra=1, wr_addr=7, wr_data=0x1234: r31 = 0x1234 and r7 is unchanged. In the same cycle read r31: 0x1234 with bypass, old value without.
- Issue r3, then r9: pend_count goes 1 then 2, and a read of r3 shows rd_pending = 1. Write r3 and issue r3 in the same cycle: r3 stays pending and pend_count stays 2.
- Issue r4, r6, r8, then flush in the same cycle as a write of 0x55 to r6: all rd_pending = 0, pend_count = 0, r6 = 0x55.
- Issue r10 and write r10 = 0xAA, assert reset mid-cycle before the edge: r10 = 0, pending = 0, pend_count = 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address type and named register indices for regfile_mp
package regfile_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int AW_DEF = $clog2(NUM_REGS_DEF);
   typedef logic [AW_DEF-1:0] reg_addr_t;
   localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
   localparam reg_addr_t REG_SP = reg_addr_t'(29);
   localparam reg_addr_t REG_FP = reg_addr_t'(30);
   localparam reg_addr_t REG_RA = reg_addr_t'(31);
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set-wins/flush-first priority and an incremental pending count
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int AW = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                clr_en,
   input  logic [AW-1:0]       clr_addr,
   input  logic                flush,
   output logic [NUM_REGS-1:0] pending,
   output logic [AW:0]         pend_count
);
   localparam int CW = AW + 1;
   logic set_v, clr_v, inc, dec;
   logic [NUM_REGS-1:0] set_mask, clr_mask, pending_next;
   always_comb begin
      set_v = iss_en && iss_addr != AW'(REG_ZERO);
      clr_v = clr_en && clr_addr != AW'(REG_ZERO);
      set_mask = set_v ? (NUM_REGS'(1) << iss_addr) : '0;
      clr_mask = clr_v ? (NUM_REGS'(1) << clr_addr) : '0;
      pending_next = flush ? '0 : (pending & ~clr_mask) | set_mask;
      inc = set_v && !pending[iss_addr];
      // a clear landing on a register being re-issued this cycle leaves it pending
      dec = clr_v && pending[clr_addr] && !(set_v && iss_addr == clr_addr);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         pend_count <= '0;
      end else begin
         pending <= pending_next;
         pend_count <= flush ? '0 : pend_count + CW'(inc) - CW'(dec);
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto read data and pending.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_READ = 2,
   parameter int RA_INDEX = NUM_REGS - 1,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_READ*AW-1:0]         rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]            rd_pending,
   input  logic                           wr_en,
   input  logic                           wr_ra,
   input  logic [AW-1:0]                  wr_addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           iss_en,
   input  logic [AW-1:0]                  iss_addr,
   input  logic                           flush,
   output logic [AW:0]                    pend_count
);
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [AW-1:0] wa;
   assign wa = wr_ra ? AW'(RA_INDEX) : wr_addr;
   // r0 is never written, so it holds its reset value of zero forever
   always_ff @(posedge clk or posedge reset) begin
      if (reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (wr_en && wa != AW'(REG_ZERO)) regs[wa] <= wr_data;
   end
   regfile_scoreboard #(.NUM_REGS(NUM_REGS), .AW(AW)) u_sb (
      .clk(clk), .reset(reset), .iss_en(iss_en), .iss_addr(iss_addr),
      .clr_en(wr_en), .clr_addr(wa), .flush(flush),
      .pending(pending), .pend_count(pend_count)
   );
   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [AW-1:0] ra;
      logic hit;
      assign ra = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign hit = wr_en && wa == ra && ra != AW'(REG_ZERO);
`else
      assign hit = 1'b0;
`endif
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_data : regs[ra];
      assign rd_pending[p] = pending[ra] && !hit;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-queue bench for regfile_mp (default 32x32, two read ports)
module tb_regfile_mp;
   import regfile_pkg::*;
   logic clk = 0, reset = 1;
   logic [9:0] rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0] rd_pending;
   logic wr_en = 0, wr_ra = 0, iss_en = 0, flush = 0;
   logic [4:0] wr_addr = '0, iss_addr = '0;
   logic [31:0] wr_data = '0;
   logic [5:0] pend_count;
   logic [31:0] exp_q [$];
   logic [31:0] e;
   int n_cmp = 0, n_err = 0;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_mp dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
      .wr_en(wr_en), .wr_ra(wr_ra), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_count(pend_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'(31 - i), 5'(i)};
         exp_q.push_back(32'h0);
         exp_q.push_back(32'h0);
         #1;
         e = exp_q.pop_front(); n_cmp++;
         if (rd_data[31:0] !== e) begin n_err++; $display("FAIL reset_p0 r%0d got %h exp %h", i, rd_data[31:0], e); end
         e = exp_q.pop_front(); n_cmp++;
         if (rd_data[63:32] !== e) begin n_err++; $display("FAIL reset_p1 r%0d got %h exp %h", 31 - i, rd_data[63:32], e); end
         n_cmp++;
         if (rd_pending !== 2'b00) begin n_err++; $display("FAIL reset_pend r%0d got %b exp 00", i, rd_pending); end
      end
      n_cmp++;
      if (pend_count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", pend_count); end
   endtask

   task automatic test_write_read();
      wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      step();
      wr_en = 0; rd_addr = {5'd5, 5'd5};
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL r5_p0 got %h exp %h", rd_data[31:0], e); end
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[63:32] !== e) begin n_err++; $display("FAIL r5_p1 got %h exp %h", rd_data[63:32], e); end
      wr_en = 1; wr_addr = 5'd0; wr_data = 32'h1111_2222;
      exp_q.push_back(32'h0);
      step();
      wr_en = 0; rd_addr = {5'd5, 5'd0};
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL r0_write got %h exp %h", rd_data[31:0], e); end
   endtask

   task automatic test_wr_ra();
      wr_en = 1; wr_ra = 1; wr_addr = 5'd7; wr_data = 32'h1234; rd_addr = {REG_RA, 5'd7};
      exp_q.push_back(32'h0);
      exp_q.push_back(BYP ? 32'h1234 : 32'h0);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL ra_same_r7 got %h exp %h", rd_data[31:0], e); end
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[63:32] !== e) begin n_err++; $display("FAIL ra_same_r31 got %h exp %h", rd_data[63:32], e); end
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1234);
      step();
      wr_en = 0; wr_ra = 0;
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL ra_after_r7 got %h exp %h", rd_data[31:0], e); end
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[63:32] !== e) begin n_err++; $display("FAIL ra_after_r31 got %h exp %h", rd_data[63:32], e); end
   endtask

   task automatic test_scoreboard();
      iss_en = 1; iss_addr = 5'd3;
      step();
      iss_addr = 5'd9;
      n_cmp++;
      if (pend_count !== 6'd1) begin n_err++; $display("FAIL sb_count1 got %0d exp 1", pend_count); end
      step();
      iss_en = 0; rd_addr = {5'd9, 5'd3};
      #1;
      n_cmp++;
      if (pend_count !== 6'd2) begin n_err++; $display("FAIL sb_count2 got %0d exp 2", pend_count); end
      n_cmp++;
      if (rd_pending !== 2'b11) begin n_err++; $display("FAIL sb_pend_r3_r9 got %b exp 11", rd_pending); end
      wr_en = 1; wr_addr = 5'd3; wr_data = 32'h33; iss_en = 1; iss_addr = 5'd3;
      exp_q.push_back(32'h33);
      step();
      wr_en = 0; iss_en = 0;
      #1;
      n_cmp++;
      if (pend_count !== 6'd2) begin n_err++; $display("FAIL sb_setwins_count got %0d exp 2", pend_count); end
      n_cmp++;
      if (rd_pending[0] !== 1'b1) begin n_err++; $display("FAIL sb_setwins_pend got %b exp 1", rd_pending[0]); end
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL sb_setwins_data got %h exp %h", rd_data[31:0], e); end
      wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99;
      exp_q.push_back(BYP ? 32'h99 : 32'h0);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[63:32] !== e) begin n_err++; $display("FAIL sb_r9_same_data got %h exp %h", rd_data[63:32], e); end
      n_cmp++;
      if (rd_pending[1] !== !BYP) begin n_err++; $display("FAIL sb_r9_same_pend got %b exp %b", rd_pending[1], !BYP); end
      step();
      wr_en = 0;
      #1;
      n_cmp++;
      if (pend_count !== 6'd1) begin n_err++; $display("FAIL sb_clear_count got %0d exp 1", pend_count); end
      n_cmp++;
      if (rd_pending !== 2'b01) begin n_err++; $display("FAIL sb_clear_pend got %b exp 01", rd_pending); end
      wr_en = 1; wr_addr = 5'd3; wr_data = 32'h34;
      step();
      wr_en = 1; wr_addr = 5'd0; iss_en = 1; iss_addr = 5'd0; rd_addr = {5'd3, 5'd0};
      step();
      wr_en = 0; iss_en = 0;
      #1;
      n_cmp++;
      if (pend_count !== 6'd0) begin n_err++; $display("FAIL sb_r0_count got %0d exp 0", pend_count); end
      n_cmp++;
      if (rd_pending !== 2'b00) begin n_err++; $display("FAIL sb_r0_pend got %b exp 00", rd_pending); end
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL sb_r0_data got %h exp %h", rd_data[31:0], e); end
   endtask

   task automatic test_flush();
      iss_en = 1;
      iss_addr = 5'd4; step();
      iss_addr = 5'd6; step();
      iss_addr = 5'd8; step();
      iss_en = 0;
      n_cmp++;
      if (pend_count !== 6'd3) begin n_err++; $display("FAIL fl_pre_count got %0d exp 3", pend_count); end
      flush = 1; wr_en = 1; wr_addr = 5'd6; wr_data = 32'h55; iss_en = 1; iss_addr = 5'd10;
      exp_q.push_back(32'h55);
      step();
      flush = 0; wr_en = 0; iss_en = 0; rd_addr = {5'd4, 5'd6};
      #1;
      n_cmp++;
      if (pend_count !== 6'd0) begin n_err++; $display("FAIL fl_count got %0d exp 0", pend_count); end
      n_cmp++;
      if (rd_pending !== 2'b00) begin n_err++; $display("FAIL fl_pend_r6_r4 got %b exp 00", rd_pending); end
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL fl_r6_data got %h exp %h", rd_data[31:0], e); end
      rd_addr = {5'd10, 5'd8};
      #1;
      n_cmp++;
      if (rd_pending !== 2'b00) begin n_err++; $display("FAIL fl_pend_r8_r10 got %b exp 00", rd_pending); end
   endtask

   task automatic test_reset_mid();
      iss_en = 1; iss_addr = 5'd12;
      step();
      n_cmp++;
      if (pend_count !== 6'd1) begin n_err++; $display("FAIL rm_pre_count got %0d exp 1", pend_count); end
      iss_addr = 5'd10; wr_en = 1; wr_addr = 5'd10; wr_data = 32'hAA; rd_addr = {5'd6, 5'd10};
      #2 reset = 1;
      #1;
      n_cmp++;
      if (pend_count !== 6'd0) begin n_err++; $display("FAIL rm_count got %0d exp 0", pend_count); end
      n_cmp++;
      if (rd_pending !== 2'b00) begin n_err++; $display("FAIL rm_pend got %b exp 00", rd_pending); end
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[63:32] !== e) begin n_err++; $display("FAIL rm_r6_data got %h exp %h", rd_data[63:32], e); end
      iss_en = 0; wr_en = 0;
      #1;
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL rm_r10_data got %h exp %h", rd_data[31:0], e); end
      step();
      reset = 0;
      step();
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if (rd_data[31:0] !== e) begin n_err++; $display("FAIL rm_r10_after got %h exp %h", rd_data[31:0], e); end
      n_cmp++;
      if (pend_count !== 6'd0 || rd_pending !== 2'b00) begin n_err++; $display("FAIL rm_after_pend got %0d/%b exp 0/00", pend_count, rd_pending); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 0;
      test_reset();
      test_write_read();
      test_wr_ra();
      test_scoreboard();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
